// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled multi-read-port RAM.
package ram_pkg;

  // Clear engine states.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_e;

  // Widest word the merge helper handles; instances zero-extend into it.
  localparam int unsigned ram_max_width_lp = 1024;

  typedef logic [ram_max_width_lp-1:0]   ram_word_t;
  typedef logic [ram_max_width_lp/8-1:0] ram_be_t;

  // Byte-enable merge: enabled lanes come from new_w, the rest from old_w.
  function automatic ram_word_t be_merge(input ram_word_t old_w,
                                         input ram_word_t new_w,
                                         input ram_be_t   be);
    ram_word_t res;
    res = old_w;
    for (int unsigned k = 0; k < ram_max_width_lp / 8; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine: walks a pointer over the whole array writing zeros.
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int unsigned depth_p          = 128,
  parameter int unsigned clear_on_reset_p = 1,
  localparam int unsigned addr_w_lp       = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 clr_we_o,
  output logic [addr_w_lp-1:0] clr_addr_o
);

  localparam logic [addr_w_lp-1:0] last_addr_lp   = addr_w_lp'(depth_p - 1);
  localparam ram_state_e           reset_state_lp = (clear_on_reset_p != 0) ? CLEAR : IDLE;

  ram_state_e           state_q;
  logic [addr_w_lp-1:0] ptr_q;

  // State and pointer: one zeroed word per cycle, clear_i restarts from 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= reset_state_lp;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
          end
        end
        CLEAR: begin
          if (clear_i) begin
            ptr_q <= '0;
          end else if (ptr_q == last_addr_lp) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + addr_w_lp'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_1wnr_be_clr.sv
// One byte-enabled write port, N write-first read ports, built-in zero clear.
module ram_1wnr_be_clr
  import ram_pkg::*;
#(
  parameter int unsigned width_p          = 32,
  parameter int unsigned depth_p          = 128,
  parameter int unsigned rd_ports_p       = 2,
  parameter int unsigned rd_reg_p         = 0,
  parameter int unsigned clear_on_reset_p = 1,
  localparam int unsigned addr_w_lp       = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            clear_i,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [addr_w_lp-1:0]            wr_addr_i,
  input  logic [width_p-1:0]              wr_data_i,
  input  logic [width_p/8-1:0]            wr_be_i,
  input  logic [rd_ports_p*addr_w_lp-1:0] rd_addr_i,
  output logic [rd_ports_p*width_p-1:0]   rd_data_o,
  output logic                            busy_o
);

  localparam logic [addr_w_lp:0] depth_w_lp = (addr_w_lp + 1)'(depth_p);

  function automatic logic [width_p-1:0] merge_w(input logic [width_p-1:0]   old_w,
                                                 input logic [width_p-1:0]   new_w,
                                                 input logic [width_p/8-1:0] be);
    return width_p'(be_merge(ram_word_t'(old_w), ram_word_t'(new_w), ram_be_t'(be)));
  endfunction

  logic                 busy;
  logic                 clr_we;
  logic [addr_w_lp-1:0] clr_addr;
  logic                 wr_in_range;
  logic                 wr_fire;

  logic [width_p-1:0] mem [depth_p];

  ram_clear_fsm #(
    .depth_p          (depth_p),
    .clear_on_reset_p (clear_on_reset_p)
  ) u_clear_fsm (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (clear_i),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign busy_o     = busy;
  assign wr_ready_o = !busy;

  // Out-of-range writes still handshake but never touch the array.
  assign wr_in_range = ({1'b0, wr_addr_i} < depth_w_lp);
  assign wr_fire     = wr_valid_i && !busy && wr_in_range;

  // Array write port: the clear engine owns the array while busy.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr_i] <= merge_w(mem[wr_addr_i], wr_data_i, wr_be_i);
    end
  end

  for (genvar p = 0; p < rd_ports_p; p++) begin : g_rd
    logic [addr_w_lp-1:0] addr;
    logic                 in_range;
    logic [width_p-1:0]   word;

    assign addr     = rd_addr_i[p*addr_w_lp +: addr_w_lp];
    assign in_range = ({1'b0, addr} < depth_w_lp);

    // Read with write-first bypass; gated by reset so a combinational port
    // shows 0 during reset even when no clear is pending.
    always_comb begin
      word = '0;
      if (reset_ni && !busy && in_range) begin
        if (wr_fire && (addr == wr_addr_i)) begin
          word = merge_w(mem[addr], wr_data_i, wr_be_i);
        end else begin
          word = mem[addr];
        end
      end
    end

    if (rd_reg_p != 0) begin : g_reg
      logic [width_p-1:0] data_q;

      // Registered read: captures the request-cycle value, bypass included.
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          data_q <= '0;
        end else begin
          data_q <= word;
        end
      end

      assign rd_data_o[p*width_p +: width_p] = data_q;
    end else begin : g_comb
      assign rd_data_o[p*width_p +: width_p] = word;
    end
  end

endmodule
